ttw_mem_resp: RTL and testbench

Memory-side responder for the table-walker line-fetch channel: accepts `mem_req` line requests (walker index plus memory cache-line number), holds them in an in-order queue for a programmable minimum latency, and returns the 512-bit line from an internal line store on `mem_res`. It sits opposite the walker's `mem_req_o`/`mem_res_i` ports, in both the fs bench and standalone walker bring-up. It replaces an untimed backing memory with a deterministic, backpressurable one. The line store is loaded through a backdoor fill port.

---
 rtl/ttw_mem_resp.sv | 129 ++++++++++++
 tb/tb_ttw_mem_resp.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttw_mem_resp.sv
// Memory-side responder for the table-walker line-fetch channel: in-order request
// queue with a programmable minimum latency, returning 512-bit lines from a local store.
module ttw_mem_resp #(
  parameter int IDX_W  = 4,
  parameter int MCN_W  = 58,
  parameter int DEPTH  = 4,
  parameter int LAT    = 2,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_req_i_valid,
  output logic              mem_req_i_ready,
  input  logic [IDX_W-1:0]  mem_req_i_bits_idx,
  input  logic [MCN_W-1:0]  mem_req_i_bits_mcn,
  output logic              mem_res_o_valid,
  input  logic              mem_res_o_ready,
  output logic [IDX_W-1:0]  mem_res_o_bits_idx,
  output logic [511:0]      mem_res_o_bits_data,
  input  logic              fill_i_valid,
  input  logic [ADDR_W-1:0] fill_i_addr,
  input  logic [511:0]      fill_i_data,
  output logic              busy_o
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               LINES    = 1 << ADDR_W;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [3:0]       LAT_T    = 4'(LAT);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]     r_wptr;
  logic [PTR_W:0]     r_rptr;
  logic [3:0]         r_timer [DEPTH];
  logic [IDX_W-1:0]   r_q_idx [DEPTH];
  logic [MCN_W-1:0]   r_q_mcn [DEPTH];
  logic [511:0]       r_store [LINES];

  logic               r_res_vld;
  logic [IDX_W-1:0]   r_res_idx;
  logic [511:0]       r_res_data;

  logic [PTR_W:0]     w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [PTR_W-1:0]   w_wslot;
  logic [PTR_W-1:0]   w_rslot;
  logic [MCN_W-1:0]   w_head_mcn;
  logic               w_in_range;
  logic [511:0]       w_line;

  assign w_count = r_wptr - r_rptr;
  assign w_full  = (w_count == FULL_CNT);
  assign w_empty = (w_count == '0);
  assign w_wslot = r_wptr[PTR_W-1:0];
  assign w_rslot = r_rptr[PTR_W-1:0];

  // Ready depends on queue state only; a pop in the same cycle does not free a slot for a push.
  assign w_push = mem_req_i_valid && !w_full;
  assign w_pop  = !w_empty && (r_timer[w_rslot] == 4'd0) && (!r_res_vld || mem_res_o_ready);

  // Line numbers beyond the store return an all-zero line.
  assign w_head_mcn = r_q_mcn[w_rslot];
  assign w_in_range = (w_head_mcn[MCN_W-1:ADDR_W] == '0);
  assign w_line     = w_in_range ? r_store[w_head_mcn[ADDR_W-1:0]] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_timer[i] <= 4'd0;
      end
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      // Every timer runs independently of queue position so back-to-back requests stream.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (PTR_W'(i) == w_wslot)) begin
          r_timer[i] <= LAT_T;
        end else if (r_timer[i] != 4'd0) begin
          r_timer[i] <= r_timer[i] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_idx[w_wslot] <= mem_req_i_bits_idx;
      r_q_mcn[w_wslot] <= mem_req_i_bits_mcn;
    end
  end

  // Store is read combinationally at pop and written at the edge, so a same-cycle
  // fill and pop to one line return the old contents.
  always_ff @(posedge clock) begin
    if (fill_i_valid) begin
      r_store[fill_i_addr] <= fill_i_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_res_vld  <= 1'b0;
      r_res_idx  <= '0;
      r_res_data <= '0;
    end else if (w_pop) begin
      r_res_vld  <= 1'b1;
      r_res_idx  <= r_q_idx[w_rslot];
      r_res_data <= w_line;
    end else if (mem_res_o_ready) begin
      r_res_vld  <= 1'b0;
    end
  end

  assign mem_req_i_ready     = !w_full;
  assign mem_res_o_valid     = r_res_vld;
  assign mem_res_o_bits_idx  = r_res_idx;
  assign mem_res_o_bits_data = r_res_data;
  assign busy_o              = !w_empty || r_res_vld;

endmodule

// File: tb/tb_ttw_mem_resp.sv
// Directed bench for ttw_mem_resp: table of per-cycle vectors plus hand-written
// sequences for backpressure, fill/pop collision and mid-operation reset.
module tb_ttw_mem_resp;

  logic          clock;
  logic          reset;
  logic          mem_req_i_valid;
  logic          mem_req_i_ready;
  logic [3:0]    mem_req_i_bits_idx;
  logic [57:0]   mem_req_i_bits_mcn;
  logic          mem_res_o_valid;
  logic          mem_res_o_ready;
  logic [3:0]    mem_res_o_bits_idx;
  logic [511:0]  mem_res_o_bits_data;
  logic          fill_i_valid;
  logic [7:0]    fill_i_addr;
  logic [511:0]  fill_i_data;
  logic          busy_o;

  int errors = 0;
  int checks = 0;

  ttw_mem_resp dut (
    .clock               (clock),
    .reset               (reset),
    .mem_req_i_valid     (mem_req_i_valid),
    .mem_req_i_ready     (mem_req_i_ready),
    .mem_req_i_bits_idx  (mem_req_i_bits_idx),
    .mem_req_i_bits_mcn  (mem_req_i_bits_mcn),
    .mem_res_o_valid     (mem_res_o_valid),
    .mem_res_o_ready     (mem_res_o_ready),
    .mem_res_o_bits_idx  (mem_res_o_bits_idx),
    .mem_res_o_bits_data (mem_res_o_bits_data),
    .fill_i_valid        (fill_i_valid),
    .fill_i_addr         (fill_i_addr),
    .fill_i_data         (fill_i_data),
    .busy_o              (busy_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1);
  end

  typedef struct {
    logic         req_v;
    logic [3:0]   idx;
    logic [57:0]  mcn;
    logic         rr;
    logic         e_vld;
    logic [3:0]   e_idx;
    logic [511:0] e_data;
    logic         e_rdy;
    logic         e_busy;
  } vec_t;

  vec_t tv [18];
  logic [511:0] model [16];
  logic [511:0] line_a5;
  logic [511:0] line_y;

  function automatic logic [511:0] line_pat(input int k);
    return {16{32'hC0DE_0000 + 32'(k)}};
  endfunction

  function automatic vec_t mk(input logic req_v, input logic [3:0] idx, input logic [57:0] mcn,
                              input logic e_vld, input logic [3:0] e_idx,
                              input logic [511:0] e_data, input logic e_busy);
    vec_t v;
    v.req_v  = req_v;
    v.idx    = idx;
    v.mcn    = mcn;
    v.rr     = 1'b1;
    v.e_vld  = e_vld;
    v.e_idx  = e_idx;
    v.e_data = e_data;
    v.e_rdy  = 1'b1;
    v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_fill(input logic [7:0] a, input logic [511:0] d);
    fill_i_valid = 1'b1;
    fill_i_addr  = a;
    fill_i_data  = d;
    tick();
    fill_i_valid = 1'b0;
    if (a < 8'd16) model[a[3:0]] = d;
  endtask

  task automatic wait_resp(input string nm, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (mem_res_o_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no response within 20 cycles, expected valid=1", nm);
    end
  endtask

  task automatic set_req(input logic v, input logic [3:0] idx, input logic [57:0] mcn);
    mem_req_i_valid    = v;
    mem_req_i_bits_idx = idx;
    mem_req_i_bits_mcn = mcn;
  endtask

  initial begin
    logic ok;
    logic acc;
    int   seen;

    reset = 1'b0;
    set_req(1'b0, 4'd0, 58'd0);
    mem_res_o_ready = 1'b1;
    fill_i_valid    = 1'b0;
    fill_i_addr     = '0;
    fill_i_data     = '0;
    line_a5 = {64{8'hA5}};
    line_y  = {16{32'hFEED_BEEF}};

    // Reset held low for three cycles.
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_valid", 512'(mem_res_o_valid), 512'd0);
    chk("rst_idx",   512'(mem_res_o_bits_idx), 512'd0);
    chk("rst_data",  mem_res_o_bits_data, 512'd0);
    chk("rst_ready", 512'(mem_req_i_ready), 512'd1);
    chk("rst_busy",  512'(busy_o), 512'd0);
    tick();

    for (int k = 0; k < 16; k++) do_fill(8'(k), line_pat(k));
    do_fill(8'h05, line_a5);

    // Per-cycle table: outputs checked at the start of a row, then the row's inputs driven.
    tv[0]  = mk(1'b1, 4'd3, 58'd5,     1'b0, 4'd0, '0,       1'b0);
    tv[1]  = mk(1'b0, 4'd0, 58'd0,     1'b0, 4'd0, '0,       1'b1);
    tv[2]  = mk(1'b0, 4'd0, 58'd0,     1'b0, 4'd0, '0,       1'b1);
    tv[3]  = mk(1'b0, 4'd0, 58'd0,     1'b0, 4'd0, '0,       1'b1);
    tv[4]  = mk(1'b0, 4'd0, 58'd0,     1'b1, 4'd3, line_a5,  1'b1);
    tv[5]  = mk(1'b1, 4'd7, 58'h100,   1'b0, 4'd0, '0,       1'b0);
    tv[6]  = mk(1'b0, 4'd0, 58'd0,     1'b0, 4'd0, '0,       1'b1);
    tv[7]  = mk(1'b0, 4'd0, 58'd0,     1'b0, 4'd0, '0,       1'b1);
    tv[8]  = mk(1'b0, 4'd0, 58'd0,     1'b0, 4'd0, '0,       1'b1);
    tv[9]  = mk(1'b0, 4'd0, 58'd0,     1'b1, 4'd7, '0,       1'b1);
    tv[10] = mk(1'b1, 4'd1, 58'd1,     1'b0, 4'd0, '0,       1'b0);
    tv[11] = mk(1'b1, 4'd2, 58'd2,     1'b0, 4'd0, '0,       1'b1);
    tv[12] = mk(1'b1, 4'd4, 58'd4,     1'b0, 4'd0, '0,       1'b1);
    tv[13] = mk(1'b0, 4'd0, 58'd0,     1'b0, 4'd0, '0,       1'b1);
    tv[14] = mk(1'b0, 4'd0, 58'd0,     1'b1, 4'd1, line_pat(1), 1'b1);
    tv[15] = mk(1'b0, 4'd0, 58'd0,     1'b1, 4'd2, line_pat(2), 1'b1);
    tv[16] = mk(1'b0, 4'd0, 58'd0,     1'b1, 4'd4, line_pat(4), 1'b1);
    tv[17] = mk(1'b0, 4'd0, 58'd0,     1'b0, 4'd0, '0,       1'b0);

    for (int r = 0; r < 18; r++) begin
      chk($sformatf("tv%0d_valid", r), 512'(mem_res_o_valid), 512'(tv[r].e_vld));
      chk($sformatf("tv%0d_ready", r), 512'(mem_req_i_ready), 512'(tv[r].e_rdy));
      chk($sformatf("tv%0d_busy", r),  512'(busy_o), 512'(tv[r].e_busy));
      if (tv[r].e_vld) begin
        chk($sformatf("tv%0d_idx", r),  512'(mem_res_o_bits_idx), 512'(tv[r].e_idx));
        chk($sformatf("tv%0d_data", r), mem_res_o_bits_data, tv[r].e_data);
      end
      set_req(tv[r].req_v, tv[r].idx, tv[r].mcn);
      mem_res_o_ready = tv[r].rr;
      tick();
    end
    set_req(1'b0, 4'd0, 58'd0);

    // Full backpressure: DEPTH in the queue plus one in the output register.
    mem_res_o_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("bp_ready%0d", k), 512'(mem_req_i_ready), 512'(k < 5));
      set_req(1'b1, 4'(k), 58'(k));
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_hold_ready%0d", k), 512'(mem_req_i_ready), 512'd0);
      chk($sformatf("bp_hold_idx%0d", k), 512'(mem_res_o_bits_idx), 512'd0);
      tick();
    end
    mem_res_o_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("bp_valid%0d", j), 512'(mem_res_o_valid), 512'd1);
      chk($sformatf("bp_idx%0d", j), 512'(mem_res_o_bits_idx), 512'(j));
      chk($sformatf("bp_data%0d", j), mem_res_o_bits_data, model[j]);
      acc = mem_req_i_valid && mem_req_i_ready;
      tick();
      if (acc) set_req(1'b0, 4'd0, 58'd0);
    end
    chk("bp_drained_valid", 512'(mem_res_o_valid), 512'd0);
    chk("bp_drained_busy", 512'(busy_o), 512'd0);

    // Fill to line 9 in the same cycle its request pops: old data returned first.
    set_req(1'b1, 4'd2, 58'd9);
    tick();
    set_req(1'b0, 4'd0, 58'd0);
    tick();
    tick();
    fill_i_valid = 1'b1;
    fill_i_addr  = 8'd9;
    fill_i_data  = line_y;
    tick();
    fill_i_valid = 1'b0;
    chk("col_valid", 512'(mem_res_o_valid), 512'd1);
    chk("col_idx",   512'(mem_res_o_bits_idx), 512'd2);
    chk("col_old_data", mem_res_o_bits_data, line_pat(9));
    tick();
    set_req(1'b1, 4'd6, 58'd9);
    tick();
    set_req(1'b0, 4'd0, 58'd0);
    wait_resp("col_second", ok);
    if (ok) begin
      chk("col_second_idx", 512'(mem_res_o_bits_idx), 512'd6);
      chk("col_new_data", mem_res_o_bits_data, line_y);
    end
    tick();

    // Reset in the middle of traffic discards everything outstanding.
    mem_res_o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(1'b1, 4'(8 + k), 58'(1 + k));
      tick();
    end
    set_req(1'b0, 4'd0, 58'd0);
    wait_resp("mid_first", ok);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 512'(mem_res_o_valid), 512'd0);
    chk("mid_rst_busy",  512'(busy_o), 512'd0);
    chk("mid_rst_ready", 512'(mem_req_i_ready), 512'd1);
    @(posedge clock);
    #3;
    reset = 1'b1;
    mem_res_o_ready = 1'b1;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (mem_res_o_valid) seen++;
    end
    chk("mid_no_resp", 512'(seen), 512'd0);
    chk("mid_after_ready", 512'(mem_req_i_ready), 512'd1);
    chk("mid_after_busy", 512'(busy_o), 512'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
